reg_file_sb: RTL
================

// Module: reg_file_sb
// PURPOSE
//  Parametrised integer register file with a built-in per-register scoreboard, for the
//  pipelined dCPU core. Two combinational read ports, one synchronous write-back port and
//  one reservation port; issue reserves a destination, and write-back retires it.
//  Busy flags on each read port let decode stall on RAW hazards without external tracking.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREG      32  number of architectural registers (power of two)
//  AW        5   address width, log2(NREG)
//  ZERO_REG  1   1: register 0 is hardwired to zero and never reserved; 0: ordinary register
//  PEND_W    2   width of per-register outstanding-write counter (max 2**PEND_W-1 in flight)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst_n      in   1     reset, asynchronous assert, active-low
//  rs_addr1   in   AW    read port 1 address
//  rs_addr2   in   AW    read port 2 address
//  rs1        out  XLEN  read port 1 data
//  rs2        out  XLEN  read port 2 data
//  rs1_busy   out  1     register at rs_addr1 has >=1 outstanding write
//  rs2_busy   out  1     register at rs_addr2 has >=1 outstanding write
//  rsv_en     in   1     reserve rsv_addr (instruction issued with destination)
//  rsv_addr   in   AW    register being reserved
//  rsv_ready  out  1     reservation on rsv_addr will be accepted this cycle
//  wren       in   1     write-back enable
//  rd_addr    in   AW    write-back address
//  reg_data   in   XLEN  write-back data
//  sb_err     out  1     sticky: write-back to register with zero outstanding count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all NREG registers cleared to 0, all counters 0, sb_err=0.
//    Hence rs1=rs2=0, rsX_busy=0, rsv_ready=1 immediately during reset. Mid-operation
//    reset discards all pending reservations; no write completes in the reset cycle.
//  - Read: rsX = rf[rs_addrX], combinational, 0-cycle latency. ZERO_REG=1: addr 0 reads 0.
//  - Write: at posedge clk, if wren (and rd_addr!=0 when ZERO_REG=1), rf[rd_addr]<=reg_data.
//    Without bypass, a read of rd_addr in the same cycle returns the old value.
//  - Counter cnt[r] (PEND_W bits) per register; busy = (cnt[r]!=0).
//    rsv accepted = rsv_en & rsv_ready & !(ZERO_REG & rsv_addr==0).
//    retire = wren & !(ZERO_REG & rd_addr==0) & cnt[rd_addr]!=0.
//    Same register, same edge: accepted rsv + retire -> cnt unchanged.
//    Accepted rsv only -> cnt+1; retire only -> cnt-1.
//  - rsv_ready = (cnt[rsv_addr] != 2**PEND_W-1) | (ZERO_REG & rsv_addr==0). A rsv_en while
//    rsv_ready=0 is dropped (no count change); issue must hold until ready.
//  - wren to register with cnt==0 (not reg 0): data is still written, cnt stays 0,
//    sb_err<=1 and holds until reset. Counter never wraps below 0 or above max.
//  - ZERO_REG=1: writes/reservations to reg 0 ignored; rsX_busy for addr 0 always 0.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: write-back forwarded to reads in the same cycle. If wren and
//    rd_addr==rs_addrX (not reg 0), rsX=reg_data. rsX_busy is then computed from the post-
//    retire count, so the last outstanding write clears busy in its write-back cycle.
//  Not defined: reads return stored value only; busy clears the cycle after write-back.
// TESTING
//  1 reset: write x5=0xDEAD, assert rst_n=0 between edges -> rs1(x5)=0 at once, busy=0, sb_err=0.
//  2 zero reg: wren rd=0 data=0xFFFF_FFFF, rsv_en addr 0 -> rs1(x0)=0, rs1_busy=0, rsv_ready=1.
//  3 RAW: rsv x3, next cycle rs1_addr=3 -> rs1_busy=1; wren x3=0x1234 -> next cycle busy=0,
//    rs1=0x1234; with REG_FILE_BYPASS_EN rs1=0x1234, busy=0 in the write-back cycle.
//  4 saturation (PEND_W=2): 3 rsv on x7 -> rsv_ready=0; 4th rsv dropped; 3 write-backs
//    -> busy drops only after the 3rd; simultaneous rsv+wb on x7 keeps count constant.
//  5 error: wren x9 with no reservation -> x9 updated, sb_err=1 and stays 1 until rst_n low.
//  6 ports: rs_addr1=rs_addr2=x4 after write 0xA5A5A5A5 -> both ports 0xA5A5A5A5.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports with busy flags, a reservation port and a write-back port.
// The master modport is the pipeline (decode/issue/write-back); the slave modport is the register file.
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs_addr1;
  logic [AW-1:0]   rs_addr2;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic            wren;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] reg_data;
  logic            sb_err;

  modport master (
    output rs_addr1, rs_addr2, rsv_en, rsv_addr, wren, rd_addr, reg_data,
    input  rs1, rs2, rs1_busy, rs2_busy, rsv_ready, sb_err
  );

  modport slave (
    input  rs_addr1, rs_addr2, rsv_en, rsv_addr, wren, rd_addr, reg_data,
    output rs1, rs2, rs1_busy, rs2_busy, rsv_ready, sb_err
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a per-register outstanding-write scoreboard for RAW hazard stalls.
// Define REG_FILE_BYPASS_EN to forward write-back data (and post-retire busy) to the read ports.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int PEND_W   = 2
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]   rf  [NREG];
  logic [PEND_W-1:0] cnt [NREG];
  logic              sb_err_q;
  logic              wr_ok;
  logic              rsv_ok;
  logic              retire;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign bus.rsv_ready = (cnt[bus.rsv_addr] != CNT_MAX) || is_zero(bus.rsv_addr);
  assign wr_ok         = bus.wren && !is_zero(bus.rd_addr);
  assign rsv_ok        = bus.rsv_en && bus.rsv_ready && !is_zero(bus.rsv_addr);
  assign retire        = wr_ok && (cnt[bus.rd_addr] != '0);
  assign bus.sb_err    = sb_err_q;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rsv_ok) inc_vec[bus.rsv_addr] = 1'b1;
    if (retire) dec_vec[bus.rd_addr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (wr_ok) begin
      rf[bus.rd_addr] <= bus.reg_data;
    end
  end

  // A reservation and a retire on the same register cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r])
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sb_err_q <= 1'b0;
    else if (wr_ok && (cnt[bus.rd_addr] == '0))
      sb_err_q <= 1'b1;
  end

  always_comb begin
    bus.rs1      = rf[bus.rs_addr1];
    bus.rs1_busy = (cnt[bus.rs_addr1] != '0);
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (bus.rd_addr == bus.rs_addr1)) begin
      bus.rs1 = bus.reg_data;
      if (retire && (cnt[bus.rs_addr1] == PEND_W'(1))) bus.rs1_busy = 1'b0;
    end
`endif
    if (is_zero(bus.rs_addr1)) begin
      bus.rs1      = '0;
      bus.rs1_busy = 1'b0;
    end
  end

  always_comb begin
    bus.rs2      = rf[bus.rs_addr2];
    bus.rs2_busy = (cnt[bus.rs_addr2] != '0);
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (bus.rd_addr == bus.rs_addr2)) begin
      bus.rs2 = bus.reg_data;
      if (retire && (cnt[bus.rs_addr2] == PEND_W'(1))) bus.rs2_busy = 1'b0;
    end
`endif
    if (is_zero(bus.rs_addr2)) begin
      bus.rs2      = '0;
      bus.rs2_busy = 1'b0;
    end
  end

endmodule
